// File: rtl/rf_access_pkg.sv
// Shared types and helpers for the two-requester register-file access arbiter.
package rf_access_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    RD      = 2'd0,
    WR      = 2'd1,
    ILLEGAL = 2'd2
  } op_e;

  // Watchdog down-counter must be able to hold the full TIMEOUT load value.
  function automatic int timeout_cnt_w(input int timeout);
    return $clog2(timeout + 1);
  endfunction

  // Asking for a read and a write at once is treated as a malformed request.
  function automatic op_e decode_op(input logic rd, input logic wr);
    if (rd && wr) return ILLEGAL;
    else if (wr)  return WR;
    else          return RD;
  endfunction

endpackage

// File: rtl/rf_rr_arb2.sv
// Two-input round-robin grant. The grant is combinational from the live
// requests; the last-served requester is remembered once its response goes out.
module rf_rr_arb2
  import rf_access_pkg::*;
(
  input  logic clk,
  input  logic res,
  input  logic req_0,
  input  logic req_1,
  input  logic update,
  input  logic served,
  output logic any_req,
  output logic grant
);

  logic last_grant;

  // Pick the requester that did not win last time when both are asking.
  always_comb begin
    any_req = req_0 | req_1;
    if (req_0 && req_1) grant = ~last_grant;
    else                grant = req_1;
  end

  // Reset to 1 so that m0 wins the very first tie.
  always_ff @(posedge clk) begin
    if (res)         last_grant <= 1'b1;
    else if (update) last_grant <= served;
  end

endmodule

// File: rtl/rf_access_arbiter.sv
// Shares one register-file software port between two requesters with
// round-robin grant, a single access in flight and a watchdog abort.
//
//   state  | meaning
//   -------+----------------------------------------------------------------
//   IDLE   | waiting for a request and for the RF complete level to be low
//   ACCESS | rf_*_en held high, watchdog counting down
//   RESP   | one-cycle response pulse to the granted requester
module rf_access_arbiter
  import rf_access_pkg::*;
#(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 64,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic [ADDR_WIDTH-1:0] m0_address,
  input  logic                  m0_read_en,
  input  logic                  m0_write_en,
  input  logic [DATA_WIDTH-1:0] m0_write_data,
  output logic [DATA_WIDTH-1:0] m0_read_data,
  output logic                  m0_invalid_address,
  output logic                  m0_access_complete,
  input  logic [ADDR_WIDTH-1:0] m1_address,
  input  logic                  m1_read_en,
  input  logic                  m1_write_en,
  input  logic [DATA_WIDTH-1:0] m1_write_data,
  output logic [DATA_WIDTH-1:0] m1_read_data,
  output logic                  m1_invalid_address,
  output logic                  m1_access_complete,
  output logic [ADDR_WIDTH-1:0] rf_address,
  output logic                  rf_read_en,
  output logic                  rf_write_en,
  output logic [DATA_WIDTH-1:0] rf_write_data,
  input  logic [DATA_WIDTH-1:0] rf_read_data,
  input  logic                  rf_invalid_address,
  input  logic                  rf_access_complete,
  output logic                  timeout_err
);

  localparam int              CNT_W    = timeout_cnt_w(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  state_e                  state;
  op_e                     op;
  logic                    gnt;
  logic [CNT_W-1:0]        wdog_cnt;
  logic [DATA_WIDTH-1:0]   resp_data;
  logic                    resp_invalid;
  logic                    resp_timeout;

  logic                    req_0;
  logic                    req_1;
  logic                    any_req;
  logic                    arb_grant;
  logic                    arb_update;
  logic                    sel_rd;
  logic                    sel_wr;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_data;

  assign req_0      = m0_read_en | m0_write_en;
  assign req_1      = m1_read_en | m1_write_en;
  assign arb_update = (state == RESP);

  rf_rr_arb2 u_arb (
    .clk     (clk),
    .res     (res),
    .req_0   (req_0),
    .req_1   (req_1),
    .update  (arb_update),
    .served  (gnt),
    .any_req (any_req),
    .grant   (arb_grant)
  );

  // Route the winning requester's command toward the issue registers.
  always_comb begin
    if (arb_grant) begin
      sel_rd   = m1_read_en;
      sel_wr   = m1_write_en;
      sel_addr = m1_address;
      sel_data = m1_write_data;
    end else begin
      sel_rd   = m0_read_en;
      sel_wr   = m0_write_en;
      sel_addr = m0_address;
      sel_data = m0_write_data;
    end
  end

  // Access sequencer: issue, watch for completion or watchdog expiry, respond.
  always_ff @(posedge clk) begin
    if (res) begin
      state              <= IDLE;
      op                 <= RD;
      gnt                <= 1'b0;
      wdog_cnt           <= '0;
      resp_data          <= '0;
      resp_invalid       <= 1'b0;
      resp_timeout       <= 1'b0;
      rf_address         <= '0;
      rf_read_en         <= 1'b0;
      rf_write_en        <= 1'b0;
      rf_write_data      <= '0;
      m0_read_data       <= '0;
      m0_invalid_address <= 1'b0;
      m0_access_complete <= 1'b0;
      m1_read_data       <= '0;
      m1_invalid_address <= 1'b0;
      m1_access_complete <= 1'b0;
      timeout_err        <= 1'b0;
    end else begin
      m0_access_complete <= 1'b0;
      m1_access_complete <= 1'b0;
      timeout_err        <= 1'b0;

      case (state)
        IDLE: begin
          // A complete level still high belongs to the previous access.
          if (any_req && !rf_access_complete) begin
            gnt          <= arb_grant;
            op           <= decode_op(sel_rd, sel_wr);
            wdog_cnt     <= CNT_LOAD;
            resp_timeout <= 1'b0;
            if (sel_rd && sel_wr) begin
              resp_data    <= '0;
              resp_invalid <= 1'b1;
              state        <= RESP;
            end else begin
              rf_address    <= sel_addr;
              rf_write_data <= sel_data;
              rf_read_en    <= sel_rd;
              rf_write_en   <= sel_wr;
              state         <= ACCESS;
            end
          end
        end

        ACCESS: begin
          if (rf_access_complete) begin
            rf_read_en   <= 1'b0;
            rf_write_en  <= 1'b0;
            resp_data    <= (op == RD) ? rf_read_data : '0;
            resp_invalid <= rf_invalid_address;
            state        <= RESP;
          end else if (wdog_cnt == CNT_LAST) begin
            rf_read_en   <= 1'b0;
            rf_write_en  <= 1'b0;
            resp_data    <= '0;
            resp_invalid <= 1'b1;
            resp_timeout <= 1'b1;
            state        <= RESP;
          end else begin
            wdog_cnt <= wdog_cnt - 1'b1;
          end
        end

        RESP: begin
          if (gnt) begin
            m1_access_complete <= 1'b1;
            m1_read_data       <= resp_data;
            m1_invalid_address <= resp_invalid;
          end else begin
            m0_access_complete <= 1'b1;
            m0_read_data       <= resp_data;
            m0_invalid_address <= resp_invalid;
          end
          timeout_err <= resp_timeout;
          state       <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_access_arbiter.sv
// Bench for rf_access_arbiter: RF stub, requester tasks, scoreboard monitor.
module tb_rf_access_arbiter;

  localparam logic [63:0] BAD_DATA = 64'hBAD0_BAD0_BAD0_BAD0;

  logic        clk;
  logic        res;
  logic [2:0]  m0_address, m1_address;
  logic        m0_read_en, m0_write_en, m1_read_en, m1_write_en;
  logic [63:0] m0_write_data, m1_write_data;
  logic [63:0] m0_read_data, m1_read_data;
  logic        m0_invalid_address, m1_invalid_address;
  logic        m0_access_complete, m1_access_complete;
  logic [2:0]  rf_address;
  logic        rf_read_en, rf_write_en;
  logic [63:0] rf_write_data;
  logic [63:0] rf_read_data;
  logic        rf_invalid_address;
  logic        rf_access_complete;
  logic        timeout_err;

  rf_access_arbiter #(.ADDR_WIDTH(3), .DATA_WIDTH(64), .TIMEOUT(16)) dut (
    .clk                (clk),
    .res                (res),
    .m0_address         (m0_address),
    .m0_read_en         (m0_read_en),
    .m0_write_en        (m0_write_en),
    .m0_write_data      (m0_write_data),
    .m0_read_data       (m0_read_data),
    .m0_invalid_address (m0_invalid_address),
    .m0_access_complete (m0_access_complete),
    .m1_address         (m1_address),
    .m1_read_en         (m1_read_en),
    .m1_write_en        (m1_write_en),
    .m1_write_data      (m1_write_data),
    .m1_read_data       (m1_read_data),
    .m1_invalid_address (m1_invalid_address),
    .m1_access_complete (m1_access_complete),
    .rf_address         (rf_address),
    .rf_read_en         (rf_read_en),
    .rf_write_en        (rf_write_en),
    .rf_write_data      (rf_write_data),
    .rf_read_data       (rf_read_data),
    .rf_invalid_address (rf_invalid_address),
    .rf_access_complete (rf_access_complete),
    .timeout_err        (timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // ---------------- RF stub: mapped addresses 0..2, variable latency ----------
  logic [63:0] rf_mem [0:7];
  bit          mem_init_done;
  bit          hang;
  int          stub_lat;
  int          lat_cnt;

  always @(posedge clk) begin
    if (res) begin
      rf_access_complete <= 1'b0;
      rf_read_data       <= '0;
      rf_invalid_address <= 1'b0;
      lat_cnt            <= 0;
      stub_lat           <= 1;
      if (!mem_init_done) begin
        rf_mem[0]     <= 64'h0000_0000_0012_ABCD;
        rf_mem[1]     <= 64'h1111_1111_1111_1111;
        rf_mem[2]     <= 64'h2222_2222_2222_2222;
        mem_init_done <= 1'b1;
      end
    end else if ((rf_read_en || rf_write_en) && !hang) begin
      if (!rf_access_complete) begin
        if (lat_cnt >= stub_lat) begin
          rf_access_complete <= 1'b1;
          rf_invalid_address <= (rf_address >= 3'd3);
          rf_read_data       <= (rf_address >= 3'd3) ? BAD_DATA : rf_mem[rf_address];
          if (rf_write_en && rf_address < 3'd3) rf_mem[rf_address] <= rf_write_data;
          stub_lat <= $urandom_range(0, 3);
          lat_cnt  <= 0;
        end else begin
          lat_cnt <= lat_cnt + 1;
        end
      end
    end else begin
      rf_access_complete <= 1'b0;
      lat_cnt            <= 0;
    end
  end

  // ---------------- reference model and scoreboard ----------------
  typedef struct {
    logic [63:0] data;
    logic        inv;
    logic        to;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  int          grant_log[$];
  logic [63:0] shadow [0:7];
  logic [63:0] held_data [0:1];
  logic        held_inv  [0:1];
  int          en_cycles = 0;
  logic        res_q;

  initial begin
    shadow[0] = 64'h0000_0000_0012_ABCD;
    shadow[1] = 64'h1111_1111_1111_1111;
    shadow[2] = 64'h2222_2222_2222_2222;
    for (int i = 3; i < 8; i++) shadow[i] = '0;
  end

  // Reset as seen by the DUT at the last active edge.
  always @(posedge clk) res_q <= res;

  task automatic check_resp(input int n, input logic [63:0] d, input logic inv);
    exp_t e;
    checks++;
    if ((n == 0 && q0.size() == 0) || (n == 1 && q1.size() == 0)) begin
      errors++;
      $display("FAIL unexpected_pulse m%0d: got a response, required none outstanding", n);
    end else begin
      e = (n == 0) ? q0.pop_front() : q1.pop_front();
      if (d !== e.data || inv !== e.inv || timeout_err !== e.to) begin
        errors++;
        $display("FAIL resp_m%0d: got data=%h inv=%b to=%b, required data=%h inv=%b to=%b",
                 n, d, inv, timeout_err, e.data, e.inv, e.to);
      end
      held_data[n] = e.data;
      held_inv[n]  = e.inv;
    end
    grant_log.push_back(n);
  endtask

  initial begin
    held_data[0] = '0; held_data[1] = '0;
    held_inv[0]  = 1'b0; held_inv[1] = 1'b0;
    forever begin
      @(negedge clk);
      if (res_q) begin
        held_data[0] = '0; held_data[1] = '0;
        held_inv[0]  = 1'b0; held_inv[1] = 1'b0;
      end else begin
        if (rf_read_en || rf_write_en) en_cycles++;
        if (rf_read_en && rf_write_en) begin
          checks++; errors++;
          $display("FAIL rf_en_overlap: got read_en=1 write_en=1, required at most one");
        end
        if (m0_access_complete) check_resp(0, m0_read_data, m0_invalid_address);
        else begin
          checks++;
          if (m0_read_data !== held_data[0] || m0_invalid_address !== held_inv[0]) begin
            errors++;
            $display("FAIL hold_m0: got data=%h inv=%b, required data=%h inv=%b",
                     m0_read_data, m0_invalid_address, held_data[0], held_inv[0]);
          end
        end
        if (m1_access_complete) check_resp(1, m1_read_data, m1_invalid_address);
        else begin
          checks++;
          if (m1_read_data !== held_data[1] || m1_invalid_address !== held_inv[1]) begin
            errors++;
            $display("FAIL hold_m1: got data=%h inv=%b, required data=%h inv=%b",
                     m1_read_data, m1_invalid_address, held_data[1], held_inv[1]);
          end
        end
        if (timeout_err && !m0_access_complete && !m1_access_complete) begin
          checks++; errors++;
          $display("FAIL timeout_err_alone: got timeout_err=1 without a response pulse, required 0");
        end
      end
    end
  end

  // ---------------- requester driver ----------------
  task automatic access(input int n, input logic rd, input logic wr,
                        input logic [2:0] addr, input logic [63:0] data, output int lat);
    exp_t e;
    bit   seen;
    e.to = 1'b0;
    if (rd && wr) begin
      e.data = '0; e.inv = 1'b1;
    end else if (hang) begin
      e.data = '0; e.inv = 1'b1; e.to = 1'b1;
    end else if (wr) begin
      e.data = '0; e.inv = (addr >= 3'd3);
      if (addr < 3'd3) shadow[addr] = data;
    end else begin
      e.inv  = (addr >= 3'd3);
      e.data = (addr >= 3'd3) ? BAD_DATA : shadow[addr];
    end
    if (n == 1) begin
      q1.push_back(e);
      m1_address = addr; m1_write_data = data; m1_read_en = rd; m1_write_en = wr;
    end else begin
      q0.push_back(e);
      m0_address = addr; m0_write_data = data; m0_read_en = rd; m0_write_en = wr;
    end
    seen = 1'b0;
    lat  = 0;
    while (!seen && lat < 200) begin
      @(negedge clk);
      lat++;
      seen = (n == 1) ? m1_access_complete : m0_access_complete;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL no_response m%0d: got no pulse in 200 cycles, required one", n);
    end
    if (n == 1) begin m1_read_en = 1'b0; m1_write_en = 1'b0; end
    else        begin m0_read_en = 1'b0; m0_write_en = 1'b0; end
    @(negedge clk);
  endtask

  task automatic check_first(input string name, input int want);
    checks++;
    if (grant_log.size() != 2 || grant_log[0] != want) begin
      errors++;
      $display("FAIL %s: got first=%0d count=%0d, required first=%0d count=2",
               name, (grant_log.size() > 0) ? grant_log[0] : -1, grant_log.size(), want);
    end
  endtask

  task automatic rand_requester(input int n, input int count);
    int          r, sel, lat;
    logic        rd, wr;
    logic [2:0]  addr;
    logic [2:0]  own;
    own = 3'(n + 1);
    for (int k = 0; k < count; k++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      r  = $urandom_range(0, 9);
      rd = (r == 0) || (r >= 5);
      wr = (r <= 4);
      sel = $urandom_range(0, 3);
      addr = (sel == 0) ? 3'd0 : (sel == 1) ? own : 3'($urandom_range(3, 7));
      if (wr && addr == 3'd0) addr = own;
      access(n, rd, wr, addr, {$urandom, $urandom}, lat);
    end
  endtask

  function automatic bit outputs_zero();
    return (m0_read_data == 0) && !m0_invalid_address && !m0_access_complete &&
           (m1_read_data == 0) && !m1_invalid_address && !m1_access_complete &&
           (rf_address == 0) && !rf_read_en && !rf_write_en && (rf_write_data == 0) &&
           !timeout_err;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int lat, e0;
    res = 1'b1; hang = 1'b0;
    m0_address = '0; m0_read_en = 0; m0_write_en = 0; m0_write_data = '0;
    m1_address = '0; m1_read_en = 0; m1_write_en = 0; m1_write_data = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (!outputs_zero()) begin
      errors++;
      $display("FAIL reset_outputs: got a nonzero output, required all zero");
    end
    res = 1'b0;
    @(negedge clk);

    // Single write from m0; rf_write_en one cycle after the request.
    fork
      access(0, 1'b0, 1'b1, 3'd1, 64'h555A_AA55_5AAA_555A, lat);
      begin
        @(negedge clk);
        checks++;
        if (!(rf_write_en && !rf_read_en && rf_address == 3'd1 &&
              rf_write_data == 64'h555A_AA55_5AAA_555A)) begin
          errors++;
          $display("FAIL write_issue: got wr=%b rd=%b addr=%0d data=%h, required wr=1 rd=0 addr=1 data=555aaa555aaa555a",
                   rf_write_en, rf_read_en, rf_address, rf_write_data);
        end
      end
    join

    // Fresh reset, then simultaneous reads: m0 wins the first tie.
    res = 1'b1;
    repeat (2) @(negedge clk);
    res = 1'b0;
    @(negedge clk);
    grant_log.delete();
    fork
      access(0, 1'b1, 1'b0, 3'd1, '0, lat);
      access(1, 1'b1, 1'b0, 3'd0, '0, lat);
    join
    check_first("tie_after_reset", 0);

    // After m0 is served alone, the next tie goes to m1.
    access(0, 1'b1, 1'b0, 3'd0, '0, lat);
    grant_log.delete();
    fork
      access(0, 1'b1, 1'b0, 3'd1, '0, lat);
      access(1, 1'b1, 1'b0, 3'd2, '0, lat);
    join
    check_first("tie_after_m0", 1);

    // Four back-to-back reads from each side alternate strictly.
    grant_log.delete();
    fork
      begin int l; for (int k = 0; k < 4; k++) access(0, 1'b1, 1'b0, 3'(k % 2), '0, l); end
      begin int l; for (int k = 0; k < 4; k++) access(1, 1'b1, 1'b0, 3'((k % 2) * 2), '0, l); end
    join
    checks++;
    if (grant_log.size() != 8) begin
      errors++;
      $display("FAIL b2b_count: got %0d responses, required 8", grant_log.size());
    end
    for (int i = 1; i < grant_log.size(); i++) begin
      checks++;
      if (grant_log[i] == grant_log[i-1]) begin
        errors++;
        $display("FAIL b2b_alternate: got m%0d twice at slot %0d, required alternation", grant_log[i], i);
      end
    end

    // Unmapped addresses from m1.
    access(1, 1'b1, 1'b0, 3'd3, '0, lat);
    access(1, 1'b0, 1'b1, 3'd5, 64'hFEED, lat);

    // Watchdog: RF never completes.
    hang = 1'b1;
    e0 = en_cycles;
    access(0, 1'b1, 1'b0, 3'd0, '0, lat);
    hang = 1'b0;
    checks++;
    if (en_cycles - e0 != 16) begin
      errors++;
      $display("FAIL timeout_en_len: got %0d enable cycles, required 16", en_cycles - e0);
    end

    // Read and write together: no RF access, response two cycles later.
    e0 = en_cycles;
    access(0, 1'b1, 1'b1, 3'd2, 64'h1234, lat);
    checks++;
    if (lat != 2 || en_cycles != e0) begin
      errors++;
      $display("FAIL illegal_op: got latency=%0d en_cycles=%0d, required latency=2 en_cycles=0",
               lat, en_cycles - e0);
    end

    // Randomized traffic from both requesters.
    fork
      rand_requester(0, 15);
      rand_requester(1, 15);
    join

    // Reset while an access is in flight.
    hang = 1'b1;
    m0_address = 3'd0; m0_read_en = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (!rf_read_en) begin
      errors++;
      $display("FAIL midreset_setup: got rf_read_en=0, required 1");
    end
    res = 1'b1; m0_read_en = 1'b0;
    @(negedge clk);
    checks++;
    if (!outputs_zero()) begin
      errors++;
      $display("FAIL midreset_outputs: got rf_read_en=%b m0_data=%h, required all outputs zero",
               rf_read_en, m0_read_data);
    end
    res = 1'b0; hang = 1'b0;
    repeat (6) @(negedge clk);

    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL outstanding: got q0=%0d q1=%0d pending, required 0", q0.size(), q1.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish within bound, required completion");
    $fatal(1);
  end

endmodule
